// File: rtl/spinner_emu_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spinner_emu_if                                                |
// | Purpose  : Bundles the request, encoder and position signals that pass   |
// |            between the input front end and spinner_emu.                  |
// | Signals  : enable  run (1) / freeze (0)                                  |
// |            cw      per-channel clockwise request, active high            |
// |            ccw     per-channel counter-clockwise request, active high    |
// |            quad    encoder outputs, channel k at [2k+1:2k]               |
// |            pos     position counters, channel k at [POS_W*k +: POS_W]    |
// |            tick    one-cycle strobe on each prescaler wrap               |
// | Modports : master drives requests, slave (the emulator) drives outputs.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface spinner_emu_if #(
  parameter int CHANNELS = 2,
  parameter int POS_W    = 8
);
  logic                      enable;
  logic [CHANNELS-1:0]       cw;
  logic [CHANNELS-1:0]       ccw;
  logic [2*CHANNELS-1:0]     quad;
  logic [POS_W*CHANNELS-1:0] pos;
  logic                      tick;

  modport master (
    output enable, cw, ccw,
    input  quad, pos, tick
  );

  modport slave (
    input  enable, cw, ccw,
    output quad, pos, tick
  );
endinterface
`default_nettype wire

// File: rtl/spinner_emu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spinner_emu                                                   |
// | Purpose  : Turns digital joystick directions into rotary-encoder signals |
// |            for cores expecting a spinner/dial. N channels, programmable  |
// |            step period, legacy pulse (MODE 0) or Gray quadrature         |
// |            (MODE 1) encoding, per-channel inversion and position count.  |
// | Ports    : clk_sys  core clock                                           |
// |            res_n    asynchronous active-low reset                        |
// |            bus      spinner_emu_if.slave:                                |
// |                       enable, cw, ccw in; quad, pos, tick out            |
// | Options  : SPINNER_ACCEL_EN - when defined, a channel held in one        |
// |            direction for ACCEL_STEPS steps gets an extra mid-period      |
// |            step, doubling its rate. Undefined: steps only on wrap.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module spinner_emu #(
  parameter int                   CHANNELS    = 2,
  parameter int                   DIV_W       = 5,
  parameter int                   STEP_DIV    = 31,
  parameter int                   MODE        = 0,
  parameter logic [CHANNELS-1:0]  INVERT      = '0,
  parameter int                   POS_W       = 8,
  parameter int                   ACCEL_STEPS = 8
) (
  input  wire logic       clk_sys,
  input  wire logic       res_n,
  spinner_emu_if.slave    bus
);

  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(STEP_DIV);
  localparam logic [1:0]       QUAD_IDLE = (MODE == 0) ? 2'b11 : 2'b00;

  // ------------------------------------------------------------------------
  // Prescaler
  // ------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             en_q;          // enable as seen on the previous cycle
  logic [DIV_W-1:0] cnt_eff;
  logic             step_main;

  // The prescaler value is held while frozen, but the first enabled cycle
  // after a freeze counts as phase 0: a partially elapsed period earns no
  // credit, so the next step lands a full STEP_DIV+1 clocks after resume.
  assign cnt_eff   = en_q ? div_q : '0;
  assign step_main = bus.enable && (cnt_eff == DIV_TC);

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (bus.enable) begin
      if (cnt_eff == DIV_TC) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = cnt_eff + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      en_q   <= bus.enable;
    end
  end

  assign bus.tick = tick_q;

`ifdef SPINNER_ACCEL_EN
  localparam logic [DIV_W-1:0] DIV_MID = DIV_W'(STEP_DIV / 2);
  localparam int               RUN_W   = $clog2(ACCEL_STEPS + 1);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(ACCEL_STEPS);

  logic mid_hit;
  assign mid_hit = bus.enable && (cnt_eff == DIV_MID);
`else
  // ACCEL_STEPS only matters with acceleration compiled in.
  logic accel_unused;
  assign accel_unused = (ACCEL_STEPS != 0);
`endif

  // ------------------------------------------------------------------------
  // Per-channel encoder
  // ------------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic             req_a, req_b;
    logic             want_cw, want_ccw;
    logic             step;
    logic [1:0]       quad_q, quad_d;
    logic [POS_W-1:0] pos_q, pos_d;

    // Inversion swaps the request lines; both lines high means no request.
    assign req_a    = INVERT[k] ? bus.ccw[k] : bus.cw[k];
    assign req_b    = INVERT[k] ? bus.cw[k]  : bus.ccw[k];
    assign want_cw  = req_a & ~req_b;
    assign want_ccw = req_b & ~req_a;

`ifdef SPINNER_ACCEL_EN
    logic [RUN_W-1:0] run_q, run_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       dir_now;

    assign dir_now = {want_cw, want_ccw};
    // The extra step reuses the normal step path so MODE and pos rules
    // apply unchanged; tick is untouched.
    assign step    = step_main | (mid_hit & (run_q == RUN_SAT));

    always_comb begin
      run_d = run_q;
      dir_d = dir_q;
      if (!bus.enable) begin
        run_d = '0;
        dir_d = 2'b00;
      end else if (step) begin
        dir_d = dir_now;
        if (dir_now == 2'b00) begin
          run_d = '0;
        end else if (dir_now != dir_q) begin
          run_d = RUN_W'(1);
        end else if (run_q != RUN_SAT) begin
          run_d = run_q + RUN_W'(1);
        end
      end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
        run_q <= '0;
        dir_q <= 2'b00;
      end else begin
        run_q <= run_d;
        dir_q <= dir_d;
      end
    end
`else
    assign step = step_main;
`endif

    if (MODE == 0) begin : g_pulse
      // Every pulse leaves idle (11) and is forced back on the next step,
      // so the fastest pulse rate is one per two steps.
      always_comb begin
        quad_d = quad_q;
        pos_d  = pos_q;
        if (step) begin
          if (quad_q != 2'b11) begin
            quad_d = 2'b11;
          end else if (want_cw) begin
            quad_d = 2'b10;
            pos_d  = pos_q + POS_W'(1);
          end else if (want_ccw) begin
            quad_d = 2'b01;
            pos_d  = pos_q - POS_W'(1);
          end
        end
      end
    end else begin : g_quad
      // The phase is recovered from the registered Gray output rather than
      // kept in a second register: phase = {q1, q1^q0}.
      logic [1:0] phase, phase_n;
      assign phase = {quad_q[1], quad_q[1] ^ quad_q[0]};

      always_comb begin
        phase_n = phase;
        pos_d   = pos_q;
        if (step) begin
          if (want_cw) begin
            phase_n = phase + 2'd1;
            pos_d   = pos_q + POS_W'(1);
          end else if (want_ccw) begin
            phase_n = phase - 2'd1;
            pos_d   = pos_q - POS_W'(1);
          end
        end
        quad_d = {phase_n[1], phase_n[1] ^ phase_n[0]};
      end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
        quad_q <= QUAD_IDLE;
        pos_q  <= '0;
      end else begin
        quad_q <= quad_d;
        pos_q  <= pos_d;
      end
    end

    assign bus.quad[2*k +: 2]      = quad_q;
    assign bus.pos[POS_W*k +: POS_W] = pos_q;
  end

endmodule
`default_nettype wire
